stopwatch: RTL and testbench
============================

Name: stopwatch

Overview:
Interval meter, the measuring counterpart of the team's interval timer. Receives a start strobe and a later stop strobe, then reports the number of clk cycles between them on a valid/ready result port. A watchdog limit aborts the measurement if stop never arrives. Intended for measuring handshake latencies and pulse spacing in bring-up and self-test logic.

Parameters:
TIMEOUT, 1000, max measurable interval in cycles (>=1); reaching it without stop ends the measurement with the timeout flag set
CW (localparam), $clog2(TIMEOUT+1), counter and result width

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset: synchronous, active-low
start  input  1  begin measurement; sampled only in IDLE
stop  input  1  end measurement; sampled only in RUNNING
busy  output  1  high in RUNNING and REPORT
result  output  CW  measured interval in cycles; valid only while result_valid
result_timeout  output  1  result ended by the TIMEOUT limit, not by stop
result_valid  output  1  result available; held until accepted
result_ready  input  1  consumer accepts result when high with result_valid

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, count 0, result 0, result_timeout 0, result_valid 0, busy 0. Reset overrides everything, including a mid-measurement or pending unaccepted result, which is discarded.
- States: IDLE, RUNNING, REPORT. Registered state and count; next-state/next-count computed combinationally.
- IDLE: stop ignored. start high at edge t -> RUNNING from t+1 with count = 1, busy = 1.
- RUNNING, per edge:
  - stop high: result <= count, result_timeout <= 0, go to REPORT.
  - else if count == TIMEOUT: result <= TIMEOUT, result_timeout <= 1, go to REPORT.
  - else count <= count + 1.
  - start ignored; no restart.
- Interval definition: start sampled at edge t, stop sampled at edge t+N -> result = N. Minimum is 1: stop on the first cycle after start.
- Simultaneous events:
  - stop on the same cycle count == TIMEOUT: stop wins, result = TIMEOUT, result_timeout = 0.
  - start and stop together in IDLE: start taken, stop ignored.
- Count never exceeds TIMEOUT; no wrap-around is possible.
- REPORT:
  - result_valid = 1 from the cycle after the transition.
  - result and result_timeout stable while result_valid && !result_ready.
  - Edge with result_valid && result_ready: result_valid <= 0, state <= IDLE, busy <= 0, count <= 0.
  - start is not accepted in that same handshake cycle; the next measurement can start in the following cycle.
- result and result_timeout keep their last values after acceptance; consumers may use them only while result_valid is high.
- result_valid, busy and result_timeout are registered outputs (no combinational path from inputs).
- Latency: stop sampled at edge s -> result_valid high after edge s. Best-case throughput is one measurement per N+2 cycles when ready is held high.

Decomposition:
- Shared package: state enum (IDLE, RUNNING, REPORT) as 2-bit typedef, reusable by the timer family.
- CW derivation is a localparam in the module.
- No sub-module; the counter is too small to justify one.

Test Plan:
- TIMEOUT=10, ready=1; start at cycle 0, stop at cycle 4 -> result_valid one cycle later with result=4, result_timeout=0; busy drops after handshake.
- TIMEOUT=10; start, stop on the next cycle -> result=1; start and stop together in IDLE -> measurement begins, no immediate result.
- TIMEOUT=10; start, stop never asserted -> result=10, result_timeout=1; stop exactly at count 10 -> result=10, result_timeout=0.
- ready=0 for 5 cycles after result_valid -> result, result_timeout, result_valid stable; start pulses during REPORT and during RUNNING ignored; acceptance on ready=1 -> IDLE the next cycle.
- rst_n low for one cycle during RUNNING (count=6) and again during REPORT with ready=0 -> all outputs 0 next cycle, IDLE; a fresh start/stop of 3 cycles then yields result=3.
- Back-to-back: ready held 1, three measurements of 2, 7 and 10 (timeout) cycles -> results 2/0, 7/0, 10/1 in order, none lost.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the timer/stopwatch family: measurement state encoding.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        REPORT  = 2'd2
    } sw_state_t;

    function automatic logic is_active(input sw_state_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/stopwatch.sv
// Interval meter: counts clk cycles from a start strobe to a stop strobe and
// reports the count, or a timeout, on a valid/ready result port.
module stopwatch
    import stopwatch_pkg::*;
#(
    parameter int  TIMEOUT = 1000,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic [CW-1:0] result,
    output logic          result_timeout,
    output logic          result_valid,
    input  logic          result_ready
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    sw_state_t     state, state_next;
    logic [CW-1:0] count, count_next;
    logic [CW-1:0] result_next;
    logic          timeout_next;
    logic          valid_next;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next   = state;
        count_next   = count;
        result_next  = result;
        timeout_next = result_timeout;
        valid_next   = result_valid;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUNNING;
                    count_next = CW'(1);
                end
            end
            RUNNING: begin
                // stop takes priority over the limit on the same cycle
                if (stop) begin
                    result_next  = count;
                    timeout_next = 1'b0;
                    valid_next   = 1'b1;
                    state_next   = REPORT;
                end else if (count == LIMIT) begin
                    result_next  = LIMIT;
                    timeout_next = 1'b1;
                    valid_next   = 1'b1;
                    state_next   = REPORT;
                end else begin
                    count_next = count + CW'(1);
                end
            end
            REPORT: begin
                if (result_valid && result_ready) begin
                    valid_next = 1'b0;
                    count_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (!rst_n) begin
            state          <= IDLE;
            count          <= '0;
            result         <= '0;
            result_timeout <= 1'b0;
            result_valid   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            count          <= count_next;
            result         <= result_next;
            result_timeout <= timeout_next;
            result_valid   <= valid_next;
            busy           <= is_active(state_next);
        end
    end

endmodule

// File: tb/tb_stopwatch.sv
// Scoreboard bench for stopwatch with TIMEOUT=10: directed measurements push
// expected results, a negedge monitor pops them on each accepted handshake.
module tb_stopwatch;

    localparam int TIMEOUT = 10;
    localparam int CW      = $clog2(TIMEOUT + 1);

    typedef struct {
        int unsigned value;
        logic        tmo;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          result_ready = 1'b1;
    logic          busy;
    logic [CW-1:0] result;
    logic          result_timeout;
    logic          result_valid;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    stopwatch #(.TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .busy           (busy),
        .result         (result),
        .result_timeout (result_timeout),
        .result_valid   (result_valid),
        .result_ready   (result_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int unsigned v, input logic t);
        exp_t e;
        e.value = v;
        e.tmo   = t;
        exp_q.push_back(e);
    endtask

    // start sampled at edge t, stop sampled at edge t+n
    task automatic measure(input int n);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        if (n > 1) cyc(n - 1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && !result_valid; i++) cyc(1);
        check(name, result_valid, 1);
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_valid"}, result_valid, 0);
    endtask

    // Monitor: a handshake is completing at the next posedge
    always @(negedge clk) begin
        if (rst_n && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0d/%0d, expected none", result, result_timeout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_result", result, e.value);
                check("sb_timeout", result_timeout, e.tmo);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(2);
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_timeout", result_timeout, 0);
        rst_n = 1'b1;
        cyc(1);

        // Basic interval of 4
        push(4, 1'b0);
        measure(4);
        check("valid_after_stop", result_valid, 1);
        check("busy_in_report", busy, 1);
        cyc(1);
        check_idle("after_accept");

        // Minimum interval, then start+stop together in IDLE
        push(1, 1'b0);
        measure(1);
        cyc(1);
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", busy, 1);
        check("startstop_novalid", result_valid, 0);
        push(3, 1'b0);
        cyc(2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(1);

        // Timeout, then stop exactly at the limit
        push(10, 1'b1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_valid("timeout_wait");
        cyc(1);
        push(10, 1'b0);
        measure(10);
        cyc(1);

        // Back-pressure with ignored start pulses in RUNNING and REPORT
        result_ready = 1'b0;
        push(5, 1'b0);
        start = 1'b1; cyc(1);
        start = 1'b0; cyc(1);
        start = 1'b1; cyc(1);
        start = 1'b0; cyc(2);
        stop  = 1'b1; cyc(1);
        stop  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", result_valid, 1);
            check("hold_result", result, 5);
            check("hold_timeout", result_timeout, 0);
            start = (i == 2);
            cyc(1);
        end
        start = 1'b0;
        result_ready = 1'b1;
        cyc(1);
        check_idle("after_backpressure");

        // Reset mid-RUNNING at count 6
        start = 1'b1; cyc(1);
        start = 1'b0; cyc(5);
        rst_n = 1'b0; cyc(1);
        rst_n = 1'b1;
        check_idle("rst_running");
        check("rst_running_result", result, 0);
        stop = 1'b1; cyc(1);
        stop = 1'b0;
        check_idle("stop_in_idle");

        // Reset during REPORT discards the pending result
        result_ready = 1'b0;
        measure(2);
        check("pending_valid", result_valid, 1);
        rst_n = 1'b0; cyc(1);
        rst_n = 1'b1;
        check_idle("rst_report");
        check("rst_report_result", result, 0);
        check("rst_report_timeout", result_timeout, 0);
        result_ready = 1'b1;
        push(3, 1'b0);
        measure(3);
        cyc(1);

        // Back-to-back with ready held high
        push(2, 1'b0);
        measure(2);
        cyc(1);
        push(7, 1'b0);
        measure(7);
        cyc(1);
        push(10, 1'b1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_valid("b2b_timeout_wait");
        cyc(1);

        cyc(3);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
